// File: rtl/edge_interval_capture_pkg.sv
// Shared defaults and FSM encoding for the edge interval capture block.
package edge_interval_capture_pkg;

   // Default interval counter width; largest reportable interval is 2^CNT_W-1.
   localparam int CNT_W_DEF       = 8;
   // Default synchronizer depth on the asynchronous input (legal 2..4).
   localparam int SYNC_STAGES_DEF = 2;

   // IDLE waits for a first toggle; MEASURE counts cycles since the last toggle.
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } state_e;

endpackage

// File: rtl/edge_interval_capture_input_synchronizer.sv
// Flop chain bringing an asynchronous level into the clk domain.
// Every stage resets to 0, so a high input at reset release shows up as a toggle.
module input_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_in,
   output logic d_out
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw input through the chain; the oldest stage is the synchronized level.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_in};
      end
   end

   assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/edge_interval_capture.sv
// Measures the clk-cycle spacing between consecutive toggles of d_async and
// presents each interval on a one-entry output register.
//
// Output handshake: a sample is transferred on every rising clk edge where
// valid && ready. valid never drops without ready, and interval/rising/sat
// hold steady while valid && !ready. A new capture arriving in the same cycle
// as a transfer reloads the register with no bubble; a capture arriving while
// the register is full and not being taken is dropped and sets sticky overrun.
module edge_interval_capture
   import edge_interval_capture_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             d_async,
   input  logic             enable,
   input  logic             ready,
   output logic             valid,
   output logic [CNT_W-1:0] interval,
   output logic             rising,
   output logic             sat,
   output logic             overrun,
   output logic             dbg_state_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             d_s;
   logic             d_prev_q;
   logic             edge_det;
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc_d;
   logic             capture;
   logic             slot_free;
   logic             valid_q;
   logic [CNT_W-1:0] interval_q;
   logic             rising_q;
   logic             sat_q;
   logic             overrun_q;

   input_synchronizer #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_in  (d_async),
      .d_out (d_s)
   );

   // A toggle is any change of the synchronized level from the previous cycle.
   assign edge_det  = d_s ^ d_prev_q;
   // The counter sticks at its maximum so long gaps report as saturated.
   assign cnt_inc_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
   // Only a toggle that closes a running measurement produces a sample.
   assign capture   = enable && (state_q == ST_MEASURE) && edge_det;
   // The register can accept a new sample if empty or being emptied this cycle.
   assign slot_free = !valid_q || ready;

   // Track the previous level, run the FSM and the interval counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_prev_q <= 1'b0;
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
      end else begin
         d_prev_q <= d_s;
         if (!enable) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (edge_det) begin
                     state_q <= ST_MEASURE;
                     cnt_q   <= CNT_ONE;
                  end
               end
               ST_MEASURE: begin
                  cnt_q <= edge_det ? CNT_ONE : cnt_inc_d;
               end
               default: begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   // Load captured intervals into the output register, or flag a drop when full.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= 1'b0;
         interval_q <= '0;
         rising_q   <= 1'b0;
         sat_q      <= 1'b0;
         overrun_q  <= 1'b0;
      end else if (capture) begin
         if (slot_free) begin
            valid_q    <= 1'b1;
            interval_q <= cnt_q;
            rising_q   <= d_s;
            sat_q      <= (cnt_q == CNT_MAX);
         end else begin
            overrun_q  <= 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_q <= 1'b0;
      end
   end

   assign valid       = valid_q;
   assign interval    = interval_q;
   assign rising      = rising_q;
   assign sat         = sat_q;
   assign overrun     = overrun_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_edge_interval_capture.sv
// Directed bench for edge_interval_capture: inputs change and outputs are
// sampled on the falling clk edge, away from the active rising edge.
`timescale 1ns/1ps
module tb_edge_interval_capture;

   logic       clk;
   logic       reset;
   logic       d_async;
   logic       enable;
   logic       ready;
   logic       valid;
   logic [7:0] interval;
   logic       rising;
   logic       sat;
   logic       overrun;
   logic       dbg_state;

   int checks   = 0;
   int failures = 0;

   edge_interval_capture #(
      .CNT_W       (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .d_async     (d_async),
      .enable      (enable),
      .ready       (ready),
      .valid       (valid),
      .interval    (interval),
      .rising      (rising),
      .sat         (sat),
      .overrun     (overrun),
      .dbg_state_o (dbg_state)
   );

   // 1 us clock period
   initial clk = 1'b0;
   always #500 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Toggle d_async, then run n cycles recording any delivered samples.
   task automatic toggle_window(input int n, output int nv, output logic [7:0] iv,
                                output logic rs, output logic st);
      nv = 0;
      iv = 8'h00;
      rs = 1'b0;
      st = 1'b0;
      d_async = ~d_async;
      repeat (n) begin
         tick(1);
         if (valid === 1'b1) begin
            nv++;
            iv = interval;
            rs = rising;
            st = sat;
         end
      end
   endtask

   int         nv;
   logic [7:0] iv;
   logic       rs;
   logic       st;
   logic       d_b;

   initial begin
      reset   = 1'b1;
      d_async = 1'b0;
      enable  = 1'b0;
      ready   = 1'b0;

      // 1: reset held while d_async toggles
      for (int i = 0; i < 4; i++) begin
         d_async = ~d_async;
         tick(1);
         check("rst_valid", valid, 1'b0);
         check("rst_interval", interval, 8'd0);
         check("rst_sat", sat, 1'b0);
         check("rst_overrun", overrun, 1'b0);
      end
      check("rst_state", dbg_state, 1'b0);
      reset = 1'b0;
      tick(4);

      // 2: toggles every 4 cycles with ready=1
      enable = 1'b1;
      ready  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         toggle_window(4, nv, iv, rs, st);
         if (k == 0) begin
            check("t2_first_none", nv, 0);
         end else begin
            check("t2_count", nv, 1);
            check("t2_interval", iv, 8'd4);
            check("t2_rising", rs, d_async);
            check("t2_sat", st, 1'b0);
         end
      end

      // 3: saturation on a 300-cycle gap, boundary 254, then a short gap
      toggle_window(300, nv, iv, rs, st);
      check("t3_pre_count", nv, 1);
      check("t3_pre_interval", iv, 8'd4);
      toggle_window(254, nv, iv, rs, st);
      check("t3_sat_count", nv, 1);
      check("t3_sat_interval", iv, 8'd255);
      check("t3_sat_flag", st, 1'b1);
      check("t3_sat_rising", rs, d_async);
      toggle_window(5, nv, iv, rs, st);
      check("t3_254_interval", iv, 8'd254);
      check("t3_254_sat", st, 1'b0);
      toggle_window(5, nv, iv, rs, st);
      check("t3_5_interval", iv, 8'd5);
      check("t3_5_sat", st, 1'b0);
      check("t3_5_rising", rs, d_async);

      // 4: ready=0, gaps 3 then 5 -> second sample dropped
      enable = 1'b0;
      tick(1);
      enable = 1'b1;
      ready  = 1'b0;
      d_async = ~d_async;
      tick(3);
      d_async = ~d_async;
      d_b = d_async;
      tick(5);
      check("t4_held_valid", valid, 1'b1);
      check("t4_held_interval", interval, 8'd3);
      check("t4_no_overrun_yet", overrun, 1'b0);
      d_async = ~d_async;
      tick(5);
      check("t4_ovr_valid", valid, 1'b1);
      check("t4_ovr_interval", interval, 8'd3);
      check("t4_ovr_rising", rising, d_b);
      check("t4_ovr_flag", overrun, 1'b1);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      check("t4_drain_valid", valid, 1'b0);
      check("t4_drain_overrun", overrun, 1'b1);

      // 5: enable dropped mid-sequence -> exactly one sample of 3
      enable = 1'b0;
      tick(1);
      enable = 1'b1;
      ready  = 1'b1;
      nv = 0;
      iv = 8'h00;
      rs = 1'b0;
      d_b = 1'b0;
      for (int i = 0; i < 18; i++) begin
         if (i == 0 || i == 6 || i == 9) d_async = ~d_async;
         if (i == 9) d_b = d_async;
         if (i == 2) enable = 1'b0;
         if (i == 4) enable = 1'b1;
         tick(1);
         if (valid === 1'b1) begin
            nv++;
            iv = interval;
            rs = rising;
         end
      end
      check("t5_count", nv, 1);
      check("t5_interval", iv, 8'd3);
      check("t5_rising", rs, d_b);

      // 6: reset with a pending sample and ready=0
      ready = 1'b0;
      d_async = ~d_async;
      tick(4);
      if (d_async == 1'b0) begin
         d_async = 1'b1;
         tick(4);
      end
      check("t6_pending_valid", valid, 1'b1);
      check("t6_pending_state", dbg_state, 1'b1);
      check("t6_pending_overrun", overrun, 1'b1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("t6_rst_valid", valid, 1'b0);
      check("t6_rst_overrun", overrun, 1'b0);
      check("t6_rst_state", dbg_state, 1'b0);
      check("t6_rst_interval", interval, 8'd0);
      // high level at release gives one edge that only starts a measurement
      tick(10);
      check("t6_release_valid", valid, 1'b0);
      check("t6_release_state", dbg_state, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
